mmio_bus_arbiter: RTL and testbench
===================================

// Module: mmio_bus_arbiter
// PURPOSE
//  Two-requester round-robin arbiter for the MMIO peripheral bus. It shares one register-slave port
//  (window at 0x4000_0000) between the CPU data port (m0) and the debug/loader port (m1).
//  Each accepted request becomes one single-cycle slave access. Read data returns one cycle later.
//  Sits between the core/debug masters and the MMIO register slaves.
// PARAMETERS
//  ADDR_W     32             address width
//  DATA_W     32             data width
//  ADDR_BASE  32'h4000_0000  base of decoded MMIO window
//  ADDR_MASK  32'hFFFF_F000  address bits compared against ADDR_BASE (4 KiB window)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  mN_req     in   1       (N=0,1) request; held until mN_gnt seen
//  mN_we      in   1       1=write, 0=read; stable while mN_req
//  mN_addr    in   ADDR_W  byte address; stable while mN_req
//  mN_wdata   in   DATA_W  write data; stable while mN_req
//  mN_gnt     out  1       one-cycle pulse: command accepted
//  mN_rvalid  out  1       one-cycle pulse: transaction complete (reads and writes)
//  mN_rdata   out  DATA_W  read data, valid with mN_rvalid (0 for writes)
//  mN_err     out  1       with mN_rvalid: address outside window
//  s_we       out  1       slave write enable, one-cycle pulse
//  s_addr     out  ADDR_W  slave address
//  s_wdata    out  DATA_W  slave write data
//  s_rdata    in   DATA_W  slave read data, combinational from s_addr
// BEHAVIOUR
//  - Reset values: state=IDLE, all gnt/rvalid/err/s_we=0, s_addr/s_wdata/mN_rdata=0, last_grant=1.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle occupancy per transaction.
//  - IDLE: at a clock edge with any req, the arbiter picks a winner and latches we/addr/wdata into
//    command regs. Then the next state is ACCESS, win_id<=winner and last_grant<=winner.
//    With no req, it stays in IDLE.
//  - Round-robin: a single req wins. When both request, the master != last_grant wins.
//    After reset, m0 wins the first tie.
//  - ACCESS (1 cycle): mN_gnt=1 for the winner. s_addr/s_wdata come from the command regs.
//    s_we=cmd_we & in_window. At the end of the cycle, rdata_q<=(cmd_we|~in_window)?0:s_rdata.
//  - RESP (1 cycle): mN_rvalid=1 and mN_rdata=rdata_q for the winner. mN_err=~in_window.
//    The loser's outputs stay 0. Next state is IDLE.
//  - Requester rule: drop req, or present a new command, in the cycle after gnt.
//    IDLE resamples only after RESP, so a held req is never double-accepted.
//  - in_window = ((cmd_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)).
//    Out-of-window accesses never pulse s_we, return rdata=0 and err=1.
//  - s_addr holds its last value outside ACCESS. s_we is 0 in every state except ACCESS.
//  - A losing requester keeps req asserted and is served next, with a worst-case wait of 3 cycles.
//  - Reset mid-transaction: immediate return to IDLE. In-flight gnt/rvalid/s_we drop to 0 and the
//    command is discarded. last_grant returns to 1.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds inputs m0_lock and m1_lock (1 bit, sampled with req).
//  - When the winner's command has lock=1, IDLE considers only that master until one of its
//    transactions with lock=0 completes. This gives an atomic read-modify-write.
//  - Reset clears the lock.
//  ARB_LOCK_EN undefined: no lock ports, pure round-robin as above.
// TESTING
//  - Reset then m0 write 0x4000_0000<=0xDEAD_BEEF -> m0_gnt at cycle 2, s_we pulse with that
//    addr/data, m0_rvalid at cycle 3, err=0.
//  - m0 read 0x4000_0000 with slave returning 0xDEAD_BEEF -> m0_rvalid, m0_rdata=0xDEAD_BEEF,
//    no s_we.
//  - m0 and m1 req together for 4 transactions each -> grants alternate m0,m1,m0,m1...,
//    each 3 cycles apart.
//  - m1 write to 0x5000_0000 -> s_we stays 0, m1_rvalid=1 with m1_err=1 and m1_rdata=0.
//  - Assert rst during ACCESS -> s_we/gnt low in the same cycle; after release the next tie grants m0.
//  - ARB_LOCK_EN: m0 lock=1 read, m1 req held, then m0 lock=0 write -> m0 served twice before m1.

Source files
------------

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
//   Two-requester round-robin arbiter that shares one MMIO register-slave port between
//   the CPU data port (m0) and the debug/loader port (m1). Every accepted request becomes
//   a single-cycle slave access. Occupancy is fixed at 3 cycles: IDLE -> ACCESS -> RESP.
//
// Optional feature: define ARB_LOCK_EN to add m0_lock_i/m1_lock_i. A locked command makes
//   IDLE consider only that master until one of its unlocked transactions is accepted.
//   This supports atomic read-modify-write.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   mN_req_i             request, held until mN_gnt_o is seen
//   mN_we_i              1 = write, 0 = read (stable while requesting)
//   mN_addr_i/wdata_i    byte address / write data (stable while requesting)
//   mN_lock_i            (ARB_LOCK_EN only) lock request, sampled with req
//   mN_gnt_o             one-cycle pulse, command accepted (ACCESS)
//   mN_rvalid_o          one-cycle pulse, transaction complete (RESP)
//   mN_rdata_o           read data with rvalid (0 for writes and out-of-window accesses)
//   mN_err_o             with rvalid, address fell outside the decoded window
//   s_we_o/addr_o/wdata_o  slave command; s_we_o pulses only in ACCESS for in-window writes
//   s_rdata_i            slave read data, combinational from s_addr_o
module mmio_bus_arbiter #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  ADDR_BASE = ADDR_W'(32'h4000_0000),
  parameter logic [ADDR_W-1:0]  ADDR_MASK = ADDR_W'(32'hFFFF_F000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock_i,
  input  logic              m1_lock_i,
`endif
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                win_q, win_d;           // 0 = m0, 1 = m1
  logic                last_q, last_d;         // master granted most recently
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                req0, req1, winner;
  logic                in_window;
  logic                in_access, in_resp;

`ifdef ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic                lock_owner_q, lock_owner_d;

  // While locked, the other master is invisible to arbitration.
  assign req0 = m0_req_i & (~lock_q | ~lock_owner_q);
  assign req1 = m1_req_i & (~lock_q | lock_owner_q);
`else
  assign req0 = m0_req_i;
  assign req1 = m1_req_i;
`endif

  // Tie goes to the master that did not win last; a lone requester always wins.
  assign winner    = (req0 & req1) ? ~last_q : req1;
  assign in_window = ((cmd_addr_q & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
`ifdef ARB_LOCK_EN
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d     = StAccess;
          win_d       = winner;
          last_d      = winner;
          cmd_we_d    = winner ? m1_we_i    : m0_we_i;
          cmd_addr_d  = winner ? m1_addr_i  : m0_addr_i;
          cmd_wdata_d = winner ? m1_wdata_i : m0_wdata_i;
`ifdef ARB_LOCK_EN
          // An unlocked command from the owner releases the lock.
          lock_d       = winner ? m1_lock_i : m0_lock_i;
          lock_owner_d = winner;
`endif
        end
      end
      StAccess: begin
        state_d = StResp;
        rdata_d = (cmd_we_q | ~in_window) ? '0 : s_rdata_i;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  assign m0_gnt_o    = in_access & ~win_q;
  assign m1_gnt_o    = in_access & win_q;
  assign m0_rvalid_o = in_resp & ~win_q;
  assign m1_rvalid_o = in_resp & win_q;
  assign m0_rdata_o  = (in_resp & ~win_q) ? rdata_q : '0;
  assign m1_rdata_o  = (in_resp & win_q) ? rdata_q : '0;
  assign m0_err_o    = in_resp & ~win_q & ~in_window;
  assign m1_err_o    = in_resp & win_q & ~in_window;

  // Command regs only change when entering ACCESS, so s_addr/s_wdata hold between accesses.
  assign s_we_o    = in_access & cmd_we_q & in_window;
  assign s_addr_o  = cmd_addr_q;
  assign s_wdata_o = cmd_wdata_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb_mmio_bus_arbiter
//   Self-checking bench for mmio_bus_arbiter. Directed scenarios followed by randomized
//   traffic, all checked against a transaction-level reference model (winner choice,
//   window decode, memory contents). Also exercises the lock feature when ARB_LOCK_EN is set.
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        lock  [2];

  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata [2];
  logic        s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          last_g;
  int          lock_own;
  logic [31:0] model_mem [16];

  // Simple register slave: 16 words, aliased across the window.
  logic [31:0] slave_mem [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slave_mem[i] <= '0;
    end else if (s_we) begin
      slave_mem[s_addr[5:2]] <= s_wdata;
    end
  end
  assign s_rdata = slave_mem[s_addr[5:2]];

  mmio_bus_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req_i    (req[0]),
    .m0_we_i     (we[0]),
    .m0_addr_i   (addr[0]),
    .m0_wdata_i  (wdata[0]),
    .m1_req_i    (req[1]),
    .m1_we_i     (we[1]),
    .m1_addr_i   (addr[1]),
    .m1_wdata_i  (wdata[1]),
`ifdef ARB_LOCK_EN
    .m0_lock_i   (lock[0]),
    .m1_lock_i   (lock[1]),
`endif
    .m0_gnt_o    (gnt[0]),
    .m0_rvalid_o (rvalid[0]),
    .m0_rdata_o  (rdata[0]),
    .m0_err_o    (err[0]),
    .m1_gnt_o    (gnt[1]),
    .m1_rvalid_o (rvalid[1]),
    .m1_rdata_o  (rdata[1]),
    .m1_err_o    (err[1]),
    .s_we_o      (s_we),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_rdata_i   (s_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Decoded window is the 4 KiB page starting at 0x4000_0000.
  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h4000_0000) && (a < 32'h4000_1000);
  endfunction

  task automatic new_cmd(input int m);
    logic [31:0] off;
    off      = 32'($urandom_range(0, 15)) << 2;
    req[m]   = 1'b1;
    we[m]    = 1'($urandom_range(0, 1));
    wdata[m] = $urandom;
    lock[m]  = 1'b0;
    case ($urandom_range(0, 7))
      5:       addr[m] = 32'h4000_1000 + off;
      6:       addr[m] = 32'h3FFF_F000 + off;
      7:       addr[m] = 32'h5000_0000 + off;
      default: addr[m] = 32'h4000_0000 + off;
    endcase
  endtask

  task automatic set_cmd(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic l);
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d; lock[m] = l;
  endtask

  task automatic model_reset();
    last_g   = 1;
    lock_own = -1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
  endtask

  // Leaves the bench at a negedge with the DUT idle and all requests low.
  task automatic apply_reset();
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0; lock[m] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check1("rst_s_we", s_we, 1'b0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_rdata0", rdata[0], 32'd0);
    check("rst_rdata1", rdata[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One arbitration slot, entered at a negedge while the DUT is idle.
  // retire: 0 = winner randomly drops or issues a new command, 1 = always new, 2 = always drop.
  task automatic round(input int retire);
    bit          c0, c1, iw;
    int          w;
    logic        we_w;
    logic [31:0] a_w, d_w, exp_rd;
    c0 = req[0] && (lock_own < 0 || lock_own == 0);
    c1 = req[1] && (lock_own < 0 || lock_own == 1);
    if (!c0 && !c1) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'd0);
      check1("idle_s_we", s_we, 1'b0);
      return;
    end
    w      = (c0 && c1) ? 1 - last_g : (c1 ? 1 : 0);
    we_w   = we[w];
    a_w    = addr[w];
    d_w    = wdata[w];
    iw     = in_win(a_w);
    exp_rd = (we_w || !iw) ? 32'd0 : model_mem[a_w[5:2]];

    @(negedge clk);  // ACCESS
    check1("gnt0", gnt[0], w == 0);
    check1("gnt1", gnt[1], w == 1);
    check1("acc_s_we", s_we, we_w && iw);
    check("acc_s_addr", s_addr, a_w);
    check("acc_s_wdata", s_wdata, d_w);
    check("acc_rvalid", 32'(rvalid), 32'd0);
    if (we_w && iw) model_mem[a_w[5:2]] = d_w;
    last_g   = w;
    lock_own = lock[w] ? w : -1;

    @(negedge clk);  // RESP
    check1("rvalid_win", rvalid[w], 1'b1);
    check1("rvalid_lose", rvalid[1-w], 1'b0);
    check("rdata_win", rdata[w], exp_rd);
    check("rdata_lose", rdata[1-w], 32'd0);
    check1("err_win", err[w], !iw);
    check1("err_lose", err[1-w], 1'b0);
    check("resp_gnt", 32'(gnt), 32'd0);
    check1("resp_s_we", s_we, 1'b0);
    if (retire == 1 || (retire == 0 && $urandom_range(0, 3) != 0)) new_cmd(w);
    else req[w] = 1'b0;

    @(negedge clk);  // IDLE
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check1("idle_s_we", s_we, 1'b0);
    check("idle_s_addr_hold", s_addr, a_w);
  endtask

  initial begin
    apply_reset();

    // m0 write then read back through the slave.
    set_cmd(0, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 1'b0);
    round(2);
    check("slave_written", slave_mem[0], 32'hDEAD_BEEF);
    set_cmd(0, 1'b0, 32'h4000_0000, 32'h0, 1'b0);
    round(2);

    // Out-of-window write from m1: no s_we, err with zero data.
    set_cmd(1, 1'b1, 32'h5000_0000, 32'h1234_5678, 1'b0);
    round(2);

    // Both held for eight slots: strict alternation, one grant every 3 cycles.
    apply_reset();
    new_cmd(0);
    new_cmd(1);
    repeat (8) round(1);

    // Reset during ACCESS: outputs drop at once and the next tie goes to m0.
    set_cmd(0, 1'b1, 32'h4000_0010, 32'hA5A5_0001, 1'b0);
    set_cmd(1, 1'b1, 32'h4000_0014, 32'hA5A5_0002, 1'b0);
    @(negedge clk);
    check1("pre_rst_gnt", gnt[1 - last_g], 1'b1);
    check1("pre_rst_s_we", s_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check1("mid_rst_s_we", s_we, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    round(1);
    round(1);
    round(2);
    round(2);

`ifdef ARB_LOCK_EN
    // Locked read by m0, m1 waiting: m0's follow-up unlocked write still wins before m1.
    apply_reset();
    set_cmd(0, 1'b0, 32'h4000_0004, 32'h0, 1'b1);
    set_cmd(1, 1'b1, 32'h4000_0008, 32'h0BAD_F00D, 1'b0);
    round(2);
    check("lock_owner_model", 32'(lock_own), 32'd0);
    set_cmd(0, 1'b1, 32'h4000_0004, 32'hC0DE_0001, 1'b0);
    round(2);
    check("lock_second_m0", 32'(last_g), 32'd0);
    round(2);
    check("lock_then_m1", 32'(last_g), 32'd1);
`endif

    // Randomized traffic.
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 1) == 1) new_cmd(m);
      end
      round(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
